// File: rtl/sum4b_bcd_display_if.sv
// Bus between the sum4b adder side and the BCD display stage:
// the captured operand, the load strobe, the conversion status and the display drive.
interface sum4b_bcd_display_if;
    logic       Cout;
    logic [3:0] S;
    logic       load;
    logic       busy;
    logic       done;
    logic [7:0] bcd;
    logic [6:0] sseg;
    logic [1:0] an;

    modport master (output Cout, S, load, input busy, done, bcd, sseg, an);
    modport slave  (input Cout, S, load, output busy, done, bcd, sseg, an);
endinterface

// File: rtl/sum4b_bcd_display.sv
// Captures the 5-bit adder result, converts it to two BCD digits by sequential double-dabble,
// and drives two multiplexed common-anode 7-segment digits. Define BLANK_ZERO_EN to blank a leading tens zero.
module sum4b_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input logic                  clk,
    input logic                  rst,
    sum4b_bcd_display_if.slave   bus
);
    localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

`ifdef BLANK_ZERO_EN
    localparam bit BLANK_ZERO = 1'b1;
`else
    localparam bit BLANK_ZERO = 1'b0;
`endif

    logic [0:0] state;
    logic [4:0] bin_sr;
    logic [7:0] scratch;
    logic [7:0] adj;
    logic [7:0] scratch_nx;
    logic [2:0] step;
    logic       done_r;
    logic [7:0] bcd_r;

    // Add-3 correction on each nibble before the shift
    always_comb begin
        adj = scratch;
        if (scratch[3:0] >= 4'd5) adj[3:0] = scratch[3:0] + 4'd3;
        if (scratch[7:4] >= 4'd5) adj[7:4] = scratch[7:4] + 4'd3;
        scratch_nx = {adj[6:0], bin_sr[4]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            step    <= '0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.load) begin
                    bin_sr  <= {bus.Cout, bus.S};
                    scratch <= '0;
                    step    <= '0;
                    state   <= CONV;
                end
            end else begin
                scratch <= scratch_nx;
                bin_sr  <= {bin_sr[3:0], 1'b0};
                step    <= step + 3'd1;
                if (step == 3'd4) begin
                    bcd_r  <= scratch_nx;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
            end
        end
    end

    logic [CW-1:0] cnt;
    logic          sel;
    logic          sel_nx;
    logic [3:0]    digit;
    logic [6:0]    seg_nx;
    logic [6:0]    sseg_r;
    logic [1:0]    an_r;

    // Segments are decoded for the slot that will be active after this edge
    always_comb begin
        sel_nx = (cnt == CNT_MAX) ? ~sel : sel;
        digit  = sel_nx ? bcd_r[7:4] : bcd_r[3:0];
        case (digit)
            4'd0:    seg_nx = 7'b1000000;
            4'd1:    seg_nx = 7'b1111001;
            4'd2:    seg_nx = 7'b0100100;
            4'd3:    seg_nx = 7'b0110000;
            4'd4:    seg_nx = 7'b0011001;
            4'd5:    seg_nx = 7'b0010010;
            4'd6:    seg_nx = 7'b0000010;
            4'd7:    seg_nx = 7'b1111000;
            4'd8:    seg_nx = 7'b0000000;
            4'd9:    seg_nx = 7'b0010000;
            default: seg_nx = 7'b1111111;
        endcase
        if (BLANK_ZERO && sel_nx && (bcd_r[7:4] == 4'd0)) seg_nx = 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sel    <= 1'b0;
            an_r   <= 2'b10;
            sseg_r <= 7'b1000000;
        end else begin
            cnt    <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            sel    <= sel_nx;
            an_r   <= sel_nx ? 2'b01 : 2'b10;
            sseg_r <= seg_nx;
        end
    end

    assign bus.busy = (state == CONV);
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.sseg = sseg_r;
    assign bus.an   = an_r;
endmodule
